// File: rtl/shift_step_sequencer.sv
// -----------------------------------------------------------------------------
// shift_step_sequencer
//
// Purpose:
//   Sequential front-end for a 4-bit combinational barrel shifter whose shift
//   port is only 2 bits wide. It accepts a shift command with an amount of up
//   to 2^AMT_W-1 over a valid/ready handshake. The command is split into steps
//   of at most MAX_STEP. Each shifter result is fed back as the operand of the
//   next step. The final value is presented on a valid/ready output port.
//
// Parameters:
//   AMT_W    - width of the requested shift amount
//   MAX_STEP - largest step issued to the shifter per cycle (1..3)
//   CNT_W    - width of the step counter; must hold ceil((2^AMT_W-1)/MAX_STEP)
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready - command handshake
//   in_data           - 4-bit operand
//   in_amt            - total shift amount
//   in_dir            - 0 = left, 1 = right (logical, zero fill)
//   sh_data/sh_amt/sh_dir - drive the shifter's data_in/shift/dir inputs
//   sh_result         - shifter data_out (combinational, same cycle)
//   out_valid/out_ready - result handshake
//   out_data          - final shifted value
//   out_steps         - number of shifter steps used for this result
// -----------------------------------------------------------------------------
module shift_step_sequencer #(
  parameter int unsigned AMT_W    = 4,
  parameter int unsigned MAX_STEP = 3,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic [3:0]       sh_data,
  output logic [1:0]       sh_amt,
  output logic             sh_dir,
  input  logic [3:0]       sh_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [CNT_W-1:0] out_steps
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] MAX_STEP_A = AMT_W'(MAX_STEP);

  state_t           state_q, state_d;
  logic [3:0]       acc_q, acc_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] steps_q, steps_d;

  logic [AMT_W-1:0] step;
  logic             accept;

  // Step for the current RUN cycle; never exceeds rem, so rem cannot underflow.
  always_comb begin
    step = rem_q;
    if (rem_q > MAX_STEP_A) begin
      step = MAX_STEP_A;
    end
  end

  // Handshake outputs are gated with rst so nothing is advertised while the
  // synchronous reset is pending.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!rst) begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    sh_data   = acc_q;
    sh_dir    = dir_q;
    sh_amt    = '0;
    out_data  = acc_q;
    out_steps = steps_q;
    if (state_q == ST_RUN) begin
      sh_amt = 2'(step);
    end
  end

  // Next-state logic. sh_result is only consumed in RUN, and in_* only on an
  // accepted handshake, so unknowns elsewhere never reach the registers.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    steps_d = steps_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = in_data;
          rem_d   = in_amt;
          dir_d   = in_dir;
          steps_d = '0;
          state_d = (in_amt == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d   = sh_result;
        rem_d   = rem_q - step;
        steps_d = steps_q + CNT_W'(1);
        if (rem_q == step) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      steps_q <= steps_d;
    end
  end

endmodule

// File: tb/tb_shift_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_step_sequencer
//
// Drives shift_step_sequencer with directed and random commands. A behavioural
// 4-bit barrel shifter closes the sh_* loop. Expected results, step counts,
// per-cycle step amounts and latency come from plain arithmetic on the
// command.
// -----------------------------------------------------------------------------
module tb_shift_step_sequencer;

  localparam int unsigned AMT_W    = 4;
  localparam int unsigned MAX_STEP = 3;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned BUDGET   = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_dir;
  logic [3:0]       sh_data;
  logic [1:0]       sh_amt;
  logic             sh_dir;
  logic [3:0]       sh_result;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_data;
  logic [CNT_W-1:0] out_steps;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural barrel shifter: logical shift with zero fill.
  always_comb begin
    if (sh_dir) sh_result = sh_data >> sh_amt;
    else        sh_result = sh_data << sh_amt;
  end

  shift_step_sequencer #(
    .AMT_W   (AMT_W),
    .MAX_STEP(MAX_STEP),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_dir   (in_dir),
    .sh_data  (sh_data),
    .sh_amt   (sh_amt),
    .sh_dir   (sh_dir),
    .sh_result(sh_result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_steps(out_steps)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Total logical shift of a 4-bit value by k positions.
  function automatic int unsigned shift_model(input int unsigned d, input bit dir,
                                              input int unsigned k);
    if (k >= 4) return 0;
    if (dir) return d / (1 << k);
    return (d * (1 << k)) % 16;
  endfunction

  function automatic int unsigned step_of(input int unsigned amt, input int unsigned i);
    int unsigned left;
    if (amt <= i * MAX_STEP) return 0;
    left = amt - i * MAX_STEP;
    return (left > MAX_STEP) ? MAX_STEP : left;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, follow it through RUN, stall the output, then retire it.
  task automatic run_cmd(input string tag, input logic [3:0] d, input int unsigned amt,
                         input bit dir, input int unsigned stall, input bit noise);
    int unsigned n, cyc;
    bit seen;
    logic [3:0] exp_val;
    n = (amt + MAX_STEP - 1) / MAX_STEP;
    exp_val = 4'(shift_model(d, dir, amt));
    cyc = 0;
    while (!in_ready && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = AMT_W'(amt);
    in_dir   = dir;
    tick();
    in_valid = 1'b0;
    in_data  = 'x;
    in_amt   = 'x;
    in_dir   = 1'bx;
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= BUDGET) begin
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      chk($sformatf("%s.sh_amt[%0d]", tag, cyc - 1), 32'(sh_amt), step_of(amt, cyc - 1));
      chk($sformatf("%s.sh_data[%0d]", tag, cyc - 1), 32'(sh_data),
          shift_model(d, dir, MAX_STEP * (cyc - 1)));
      chk($sformatf("%s.sh_dir[%0d]", tag, cyc - 1), 32'(sh_dir), 32'(dir));
      chk($sformatf("%s.busy_ready[%0d]", tag, cyc - 1), 32'(in_ready), 32'd0);
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 4'($urandom);
        in_amt   = AMT_W'($urandom);
        in_dir   = 1'($urandom);
      end
      tick();
      cyc++;
    end
    chk({tag, ".out_valid_seen"}, 32'(seen), 32'd1);
    chk({tag, ".latency"}, cyc, 1 + n);
    chk({tag, ".out_data"}, 32'(out_data), 32'(exp_val));
    chk({tag, ".out_steps"}, 32'(out_steps), n);
    chk({tag, ".done_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".done_sh_amt"}, 32'(sh_amt), 32'd0);
    for (int unsigned s = 0; s < stall; s++) begin
      tick();
      chk($sformatf("%s.stall_valid[%0d]", tag, s), 32'(out_valid), 32'd1);
      chk($sformatf("%s.stall_data[%0d]", tag, s), 32'(out_data), 32'(exp_val));
      chk($sformatf("%s.stall_steps[%0d]", tag, s), 32'(out_steps), n);
      chk($sformatf("%s.stall_ready[%0d]", tag, s), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, ".retired_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".retired_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".retired_sh_amt"}, 32'(sh_amt), 32'd0);
  endtask

  initial begin
    logic [3:0] rd;
    int unsigned ra, rs;
    bit rdir;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 'x;
    in_amt    = 'x;
    in_dir    = 1'bx;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_hold.in_ready", 32'(in_ready), 32'd0);
    chk("rst_hold.out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_data", 32'(out_data), 32'd0);
    chk("reset.out_steps", 32'(out_steps), 32'd0);
    chk("reset.sh_amt", 32'(sh_amt), 32'd0);
    tick();

    run_cmd("d1011_a2_l", 4'b1011, 2, 1'b0, 0, 1'b0);
    run_cmd("d0001_a7_l", 4'b0001, 7, 1'b0, 0, 1'b0);
    run_cmd("d1101_a0_r", 4'b1101, 0, 1'b1, 0, 1'b0);
    run_cmd("d1000_a4_r_stall", 4'b1000, 4, 1'b1, 5, 1'b1);
    run_cmd("d1111_a15_l", 4'b1111, 15, 1'b0, 1, 1'b0);

    // Reset during the second RUN cycle of a 9-position command.
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_amt   = AMT_W'(9);
    in_dir   = 1'b0;
    tick();
    in_valid = 1'b0;
    in_data  = 'x;
    in_amt   = 'x;
    in_dir   = 1'bx;
    chk("abort.run1_sh_amt", 32'(sh_amt), 32'd3);
    tick();
    chk("abort.run2_sh_amt", 32'(sh_amt), 32'd3);
    rst = 1'b1;
    #1;
    chk("abort.rst_ready", 32'(in_ready), 32'd0);
    chk("abort.rst_valid", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort.idle_ready", 32'(in_ready), 32'd1);
    chk("abort.idle_valid", 32'(out_valid), 32'd0);
    chk("abort.idle_acc", 32'(out_data), 32'd0);
    chk("abort.idle_steps", 32'(out_steps), 32'd0);
    chk("abort.idle_sh_amt", 32'(sh_amt), 32'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort.no_valid[%0d]", i), 32'(out_valid), 32'd0);
    end
    run_cmd("d0110_a1_r", 4'b0110, 1, 1'b1, 0, 1'b0);

    for (int unsigned t = 0; t < 40; t++) begin
      rd   = 4'($urandom);
      ra   = $urandom_range(0, 15);
      rdir = 1'($urandom);
      rs   = $urandom_range(0, 3);
      run_cmd($sformatf("rand%0d", t), rd, ra, rdir, rs, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
